// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Recovers the four digit values shown on a multiplexed 7-segment display
//   by watching its scanned digit-enable and segment lines. Each sample must
//   stay unchanged for STABLE_CYC consecutive cycles before it is captured,
//   and it is captured only once per stable window. A small HUNT/TRACK FSM
//   assembles the four captured digits into frames.
//
//   Optional feature macro: SEG_ORDER_CHECK_EN
//     defined   : TRACK enforces scan order 1110,1101,1011,0111; an
//                 out-of-order digit raises order_err and drops back to HUNT
//     undefined : TRACK accepts digits in any order; order_err is tied low
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous active-high reset
//     DIGIT[3:0]  active-low digit enables
//     DISPLAY[6:0] active-low segments {g,f,e,d,c,b,a}
//     val0..val3  decoded value for digit 1110/1101/1011/0111
//     seg_valid   bit i set once val<i> holds a capture of the current frame
//     frame_pulse one-cycle pulse on frame completion
//     frame_cnt   completed-frame counter, wraps 255 -> 0
//     digit_err   sticky: a digit enable with more than one active bit
//     bad_code    sticky: an unrecognised segment pattern was stored
//     order_err   sticky: out-of-order digit (SEG_ORDER_CHECK_EN only)
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DIGIT,
    input  logic [6:0] DISPLAY,
    output logic [3:0] val0,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic [3:0] seg_valid,
    output logic       frame_pulse,
    output logic [7:0] frame_cnt,
    output logic       digit_err,
    output logic       bad_code,
    output logic       order_err
);

    localparam int unsigned RUN_W = 5;
    localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(STABLE_CYC);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(STABLE_CYC + 1);

    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

    // Segment pattern to digit code; unknown patterns map to 14.
    function automatic logic [3:0] decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b0001000: code = 4'd10;
            7'b0000011: code = 4'd11;
            7'b0111111: code = 4'd12;
            7'b1111111: code = 4'd15;
            default:    code = 4'd14;
        endcase
        return code;
    endfunction

    // Sampled bus and run length of identical samples.
    logic [3:0]       dig_q;
    logic [6:0]       disp_q;
    logic             smp_vld_q;
    logic [RUN_W-1:0] run_q, run_d;

    // Run counter saturates above the target so a held value captures once.
    always_comb begin
        run_d = RUN_W'(1);
        if (smp_vld_q && DIGIT == dig_q && DISPLAY == disp_q) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q     <= 4'hF;
            disp_q    <= 7'h7F;
            smp_vld_q <= 1'b0;
            run_q     <= '0;
        end else begin
            dig_q     <= DIGIT;
            disp_q    <= DISPLAY;
            smp_vld_q <= 1'b1;
            run_q     <= run_d;
        end
    end

    logic       capture_c;
    logic       legal_c;
    logic       multi_c;
    logic [1:0] idx_c;
    logic [3:0] code_c;

    assign capture_c = (run_q == RUN_TGT);
    assign code_c    = decode(disp_q);

    // Classify the captured digit enable.
    always_comb begin
        legal_c = 1'b0;
        multi_c = 1'b0;
        idx_c   = 2'd0;
        case (dig_q)
            4'b1110: begin legal_c = 1'b1; idx_c = 2'd0; end
            4'b1101: begin legal_c = 1'b1; idx_c = 2'd1; end
            4'b1011: begin legal_c = 1'b1; idx_c = 2'd2; end
            4'b0111: begin legal_c = 1'b1; idx_c = 2'd3; end
            4'b1111: ;
            default: multi_c = 1'b1;
        endcase
    end

    state_t     state_q, state_d;
    logic [3:0] val_q [4];
    logic [3:0] val_d [4];
    logic [3:0] seg_valid_q, seg_valid_d;
    logic       frame_pulse_q, frame_pulse_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       digit_err_q, digit_err_d;
    logic       bad_code_q, bad_code_d;
    logic       store_c;
    logic [3:0] valid_nxt_c;

`ifdef SEG_ORDER_CHECK_EN
    logic       order_err_q, order_err_d;
    logic [1:0] exp_idx_c;

    // Expected next digit follows from the in-order fill pattern.
    always_comb begin
        case (seg_valid_q)
            4'b0001: exp_idx_c = 2'd1;
            4'b0011: exp_idx_c = 2'd2;
            4'b0111: exp_idx_c = 2'd3;
            default: exp_idx_c = 2'd0;
        endcase
    end
`endif

    assign valid_nxt_c = seg_valid_q | (4'b0001 << idx_c);

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        val_d         = val_q;
        seg_valid_d   = seg_valid_q;
        frame_pulse_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        digit_err_d   = digit_err_q;
        bad_code_d    = bad_code_q;
        store_c       = 1'b0;
`ifdef SEG_ORDER_CHECK_EN
        order_err_d   = order_err_q;
`endif
        if (capture_c) begin
            if (multi_c) begin
                digit_err_d = 1'b1;
            end else if (legal_c) begin
                case (state_q)
                    HUNT:  store_c = (idx_c == 2'd0);
                    TRACK: begin
`ifdef SEG_ORDER_CHECK_EN
                        if (idx_c == exp_idx_c) begin
                            store_c = 1'b1;
                        end else begin
                            order_err_d = 1'b1;
                            seg_valid_d = 4'b0000;
                            state_d     = HUNT;
                        end
`else
                        store_c = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
        if (store_c) begin
            val_d[idx_c] = code_c;
            state_d      = TRACK;
            if (code_c == 4'd14) begin
                bad_code_d = 1'b1;
            end
            if (valid_nxt_c == 4'b1111) begin
                frame_pulse_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 8'd1;
                seg_valid_d   = 4'b0000;
            end else begin
                seg_valid_d   = valid_nxt_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            val_q         <= '{default: 4'd12};
            seg_valid_q   <= 4'b0000;
            frame_pulse_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            digit_err_q   <= 1'b0;
            bad_code_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            val_q         <= val_d;
            seg_valid_q   <= seg_valid_d;
            frame_pulse_q <= frame_pulse_d;
            frame_cnt_q   <= frame_cnt_d;
            digit_err_q   <= digit_err_d;
            bad_code_q    <= bad_code_d;
        end
    end

`ifdef SEG_ORDER_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end
    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

    assign val0        = val_q[0];
    assign val1        = val_q[1];
    assign val2        = val_q[2];
    assign val3        = val_q[3];
    assign seg_valid   = seg_valid_q;
    assign frame_pulse = frame_pulse_q;
    assign frame_cnt   = frame_cnt_q;
    assign digit_err   = digit_err_q;
    assign bad_code    = bad_code_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYC = 2.
module tb_seg_scan_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic [3:0] val0, val1, val2, val3;
    logic [3:0] seg_valid;
    logic       frame_pulse;
    logic [7:0] frame_cnt;
    logic       digit_err, bad_code, order_err;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_base;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S6    = 7'b0000010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] S8    = 7'b0000000;
    localparam logic [6:0] S9    = 7'b0010000;
    localparam logic [6:0] SBAD  = 7'b1010101;
    localparam logic [6:0] SBLNK = 7'b1111111;

    seg_scan_decoder #(.STABLE_CYC(2)) dut (
        .clk(clk), .rst(rst), .DIGIT(DIGIT), .DISPLAY(DISPLAY),
        .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .seg_valid(seg_valid), .frame_pulse(frame_pulse), .frame_cnt(frame_cnt),
        .digit_err(digit_err), .bad_code(bad_code), .order_err(order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (frame_pulse) pulse_cnt++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [3:0] d, input logic [6:0] s);
        DIGIT   = d;
        DISPLAY = s;
        step(4);
    endtask

    // Drive the last digit of a frame and check the one-cycle pulse.
    task automatic last_slot(input logic [3:0] d, input logic [6:0] s, input logic [7:0] cnt);
        DIGIT   = d;
        DISPLAY = s;
        step(3);
        chk("pulse_hi", 16'(frame_pulse), 16'd1);
        chk("cnt_after_frame", 16'(frame_cnt), 16'(cnt));
        chk("seg_valid_cleared", 16'(seg_valid), 16'd0);
        step(1);
        chk("pulse_lo", 16'(frame_pulse), 16'd0);
    endtask

    task automatic do_reset(input logic [3:0] d, input logic [6:0] s);
        rst     = 1'b1;
        DIGIT   = d;
        DISPLAY = s;
        step(2);
        chk("rst_val0", 16'(val0), 16'd12);
        chk("rst_val1", 16'(val1), 16'd12);
        chk("rst_val2", 16'(val2), 16'd12);
        chk("rst_val3", 16'(val3), 16'd12);
        chk("rst_seg_valid", 16'(seg_valid), 16'd0);
        chk("rst_pulse", 16'(frame_pulse), 16'd0);
        chk("rst_cnt", 16'(frame_cnt), 16'd0);
        chk("rst_digit_err", 16'(digit_err), 16'd0);
        chk("rst_bad_code", 16'(bad_code), 16'd0);
        chk("rst_order_err", 16'(order_err), 16'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        DIGIT   = 4'hF;
        DISPLAY = SBLNK;
        do_reset(4'hF, SBLNK);

        // Basic frame 1,2,3,4.
        slot(4'b1110, S1);
        chk("f1_seg_valid0", 16'(seg_valid), 16'b0001);
        slot(4'b1101, S2);
        slot(4'b1011, S3);
        chk("f1_seg_valid2", 16'(seg_valid), 16'b0111);
        last_slot(4'b0111, S4, 8'd1);
        chk("f1_val0", 16'(val0), 16'd1);
        chk("f1_val1", 16'(val1), 16'd2);
        chk("f1_val2", 16'(val2), 16'd3);
        chk("f1_val3", 16'(val3), 16'd4);
        chk("f1_pulses", 16'(pulse_cnt), 16'd1);
        chk("f1_digit_err", 16'(digit_err), 16'd0);
        chk("f1_bad_code", 16'(bad_code), 16'd0);

        // Glitch at the end of the 1101 slot, bad code on 1011.
        slot(4'b1110, S5);
        DIGIT   = 4'b1101;
        DISPLAY = S6;
        step(3);
        chk("g_val1_stable", 16'(val1), 16'd6);
        chk("g_seg_valid", 16'(seg_valid), 16'b0011);
        DISPLAY = S8;
        step(1);
        slot(4'b1011, SBAD);
        chk("g_val1_no_glitch", 16'(val1), 16'd6);
        chk("bad_val2", 16'(val2), 16'd14);
        chk("bad_flag", 16'(bad_code), 16'd1);
        chk("bad_seg_valid", 16'(seg_valid), 16'b0111);
        last_slot(4'b0111, S7, 8'd2);
        chk("f2_val0", 16'(val0), 16'd5);
        chk("f2_val3", 16'(val3), 16'd7);

        // Multi-zero digit enable.
        DIGIT   = 4'b1100;
        DISPLAY = SBLNK;
        step(3);
        chk("de_flag", 16'(digit_err), 16'd1);
        chk("de_seg_valid", 16'(seg_valid), 16'd0);
        chk("de_cnt", 16'(frame_cnt), 16'd2);
        chk("de_val0", 16'(val0), 16'd5);
        DIGIT = 4'hF;
        step(2);

        // Out-of-order 1110 then 1011.
        slot(4'b1110, S0);
        slot(4'b1011, S9);
        chk("oo_val0", 16'(val0), 16'd0);
`ifdef SEG_ORDER_CHECK_EN
        chk("oo_order_err", 16'(order_err), 16'd1);
        chk("oo_seg_valid", 16'(seg_valid), 16'b0000);
        chk("oo_val2", 16'(val2), 16'd14);
        slot(4'b1101, S3);
        chk("oo_hunt_ignores", 16'(seg_valid), 16'b0000);
        chk("oo_hunt_val1", 16'(val1), 16'd6);
`else
        chk("oo_order_err", 16'(order_err), 16'd0);
        chk("oo_seg_valid", 16'(seg_valid), 16'b0101);
        chk("oo_val2", 16'(val2), 16'd9);
        slot(4'b1101, S3);
        chk("oo_any_order", 16'(seg_valid), 16'b0111);
        chk("oo_val1", 16'(val1), 16'd3);
`endif

        // 256 frames wrap the counter; then reset mid frame 257.
        do_reset(4'hF, SBLNK);
        pulse_base = pulse_cnt;
        for (int f = 0; f < 256; f++) begin
            slot(4'b1110, S0);
            slot(4'b1101, S1);
            slot(4'b1011, S2);
            slot(4'b0111, S3);
            if (f == 254) chk("wrap_cnt_255", 16'(frame_cnt), 16'd255);
        end
        chk("wrap_cnt_0", 16'(frame_cnt), 16'd0);
        chk("wrap_pulses", 16'(pulse_cnt - pulse_base), 16'd256);
        chk("wrap_val3", 16'(val3), 16'd3);
        slot(4'b1110, S5);
        slot(4'b1101, S6);
        chk("mid_seg_valid", 16'(seg_valid), 16'b0011);
        chk("mid_val1", 16'(val1), 16'd6);
        do_reset(4'b1110, S1);

        // Held input across reset still needs a fresh stable window.
        step(2);
        chk("post_rst_no_early", 16'(seg_valid), 16'b0000);
        step(1);
        chk("post_rst_capture", 16'(seg_valid), 16'b0001);
        chk("post_rst_val0", 16'(val0), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 2, giving the consecutive identical samples (1..15) required before a digit is captured.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port DIGIT, input, 4 bits: active-low digit enables of the scanned display bus.
REQ-005 The block SHALL have port DISPLAY, input, 7 bits: active-low segments {g,f,e,d,c,b,a} of the scanned display bus.
REQ-006 The block SHALL have ports val0..val3, outputs, 4 bits each: decoded codes for DIGIT 1110, 1101, 1011 and 0111 respectively.
REQ-007 The block SHALL have port seg_valid, output, 4 bits: bit i high once val<i> holds a capture for the current frame.
REQ-008 The block SHALL have port frame_pulse, output, 1 bit: single-cycle pulse when a complete four-digit frame is captured.
REQ-009 The block SHALL have port frame_cnt, output, 8 bits: number of completed frames, wrapping from 255 to 0.
REQ-010 The block SHALL have ports digit_err, bad_code and order_err, outputs, 1 bit each: sticky error flags.

Function
REQ-011 Inputs SHALL be registered once; the capture event SHALL occur at sample k when samples k-STABLE_CYC+1..k are identical and sample k-STABLE_CYC differs; the capture occurs once per stable window.
REQ-012 Outputs affected by a capture SHALL update on the clock edge following sample k (one cycle latency).
REQ-013 A captured DIGIT of 1111 SHALL be ignored, with no state change.
REQ-014 A captured DIGIT with more than one zero bit SHALL set digit_err and be ignored otherwise.
REQ-015 DISPLAY decode SHALL be: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9, 0001000=10 (A), 0000011=11 (b), 0111111=12 (dash), 1111111=15 (blank).
REQ-016 Any other DISPLAY pattern SHALL decode to 14 and set bad_code; the value is still stored.
REQ-017 The FSM SHALL have two states, HUNT and TRACK; the reset state SHALL be HUNT.
REQ-018 In HUNT, a legal capture of DIGIT 1110 SHALL store val0, set seg_valid to 0001 and move to TRACK; other digits SHALL be ignored.
REQ-019 In TRACK, the expected order SHALL be 1110, 1101, 1011, 0111; a legal capture of the expected digit SHALL store the value and set its seg_valid bit.
REQ-020 A capture of 0111 completing seg_valid=1111 SHALL pulse frame_pulse, increment frame_cnt, keep val0..val3, clear seg_valid to 0000 and stay in TRACK expecting 1110.
REQ-021 If a capture sets a sticky error flag in the same cycle that a frame completes, the frame SHALL still complete.

Reset
REQ-022 On rst, the block SHALL set val0..val3=12, seg_valid=0000, frame_pulse=0, frame_cnt=0, all error flags=0, FSM=HUNT and clear the stability history.
REQ-023 A rst asserted mid-frame SHALL discard the partial frame; the first capture after reset SHALL require a full STABLE_CYC window of new samples.

Configuration
REQ-024 With macro SEG_ORDER_CHECK_EN defined, an out-of-order legal capture in TRACK SHALL set order_err, clear seg_valid and return the FSM to HUNT; the value is not stored.
REQ-025 With SEG_ORDER_CHECK_EN undefined, order_err SHALL be tied 0 and TRACK SHALL accept legal digits in any order, each storing its value and setting its seg_valid bit.
REQ-026 With SEG_ORDER_CHECK_EN undefined, frame completion (REQ-020) SHALL occur on whichever capture makes seg_valid=1111.

Verification
REQ-027 Scenario: after reset, drive DIGIT 1110/1101/1011/0111 with DISPLAY codes 1, 2, 3, 4, each held 4 cycles -> val0..3 = 1,2,3,4, one frame_pulse, frame_cnt=1.
REQ-028 Scenario: with STABLE_CYC=2, drive a 1-cycle glitch of DISPLAY=0000000 inside the 1101 slot -> no capture of 8; val1 keeps its stable value.
REQ-029 Scenario: drive DIGIT=1100 stable for 3 cycles -> digit_err=1; val, seg_valid and frame_cnt unchanged.
REQ-030 Scenario: drive DISPLAY=1010101 on 1011 -> val2=14, bad_code=1, and the frame still completes.
REQ-031 Scenario: with SEG_ORDER_CHECK_EN defined, drive order 1110, 1011 -> order_err=1, seg_valid=0000, FSM=HUNT; without the macro, the same stimulus gives seg_valid=0101.
REQ-032 Scenario: run 256 frames, asserting rst in the middle of frame 257 -> frame_cnt wraps to 0 after frame 256, and after rst all outputs equal their REQ-022 values.
